// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler
// Shares one FFT core between NUM_CH sample streams. Each frame: round-robin
// grant, one config word, exactly FFT_LEN samples with a generated tlast, and
// a channel tag queued so the matching FFT output frame can be identified.
module fft_frame_scheduler #(
  parameter int NUM_CH       = 4,
  parameter int FFT_LEN      = 1024,
  parameter int DW           = 48,
  parameter int MAX_INFLIGHT = 4,
  parameter int CHW          = $clog2(NUM_CH)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_CH*DW-1:0] ch_tdata,
  input  logic [NUM_CH-1:0]    ch_tvalid,
  output logic [NUM_CH-1:0]    ch_tready,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH-1:0]    ch_inv,
  output logic [7:0]           s_axis_config_tdata,
  output logic                 s_axis_config_tvalid,
  input  logic                 s_axis_config_tready,
  output logic [DW-1:0]        s_axis_data_tdata,
  output logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tlast,
  input  logic                 s_axis_data_tready,
  input  logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tlast,
  input  logic                 event_tlast_unexpected,
  input  logic                 event_tlast_missing,
  output logic [CHW-1:0]       frame_ch_id,
  output logic                 frame_ch_vld,
  output logic                 busy,
  output logic                 err_flag
);

  localparam int LW = $clog2(FFT_LEN);
  // One pointer bit minimum so a single-entry tag queue still has legal widths.
  localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [LW-1:0] LAST_IDX = LW'(FFT_LEN - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CFG    = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  state_e            state_r, state_nxt_s;
  logic [CHW-1:0]    gnt_r, last_gnt_r;
  logic              cfg_fwd_r;
  logic [LW-1:0]     smp_cnt_r;
  logic [CHW-1:0]    tag_mem_r [2**PW];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     tag_cnt_r;
  logic              err_r;

  logic [NUM_CH-1:0] elig_s;
  logic [CHW-1:0]    pick_s, idx_s;
  logic              pick_vld_s, hit_s;
  logic              full_s, empty_s;
  logic              cfg_hs_s, data_hs_s, last_s;
  logic              push_s, pop_req_s, pop_s;

  assign full_s    = (tag_cnt_r == FULL_CNT);
  assign empty_s   = (tag_cnt_r == '0);
  assign cfg_hs_s  = (state_r == ST_CFG) & s_axis_config_tready;
  assign data_hs_s = (state_r == ST_STREAM) & ch_tvalid[gnt_r] & s_axis_data_tready;
  assign last_s    = (smp_cnt_r == LAST_IDX);
  assign push_s    = data_hs_s & last_s;
  assign pop_req_s = m_axis_data_tvalid & m_axis_data_tlast;
  assign pop_s     = pop_req_s & ~empty_s;

  // Round-robin pick: first eligible channel strictly after the last finished grant.
  always_comb begin
    elig_s     = ch_req & {NUM_CH{~full_s}};
    pick_s     = '0;
    pick_vld_s = 1'b0;
    idx_s      = '0;
    hit_s      = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx_s      = CHW'((int'(last_gnt_r) + i) % NUM_CH);
      hit_s      = elig_s[idx_s] & ~pick_vld_s;
      pick_s     = hit_s ? idx_s : pick_s;
      pick_vld_s = pick_vld_s | elig_s[idx_s];
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a granted frame always runs to its tlast.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s) state_nxt_s = ST_CFG;
        else            state_nxt_s = ST_IDLE;
      end
      ST_CFG: begin
        if (cfg_hs_s) state_nxt_s = ST_STREAM;
        else          state_nxt_s = ST_CFG;
      end
      ST_STREAM: begin
        if (push_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_STREAM;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant bookkeeping, latched config direction and per-frame sample counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      gnt_r      <= '0;
      last_gnt_r <= CHW'(NUM_CH - 1);
      cfg_fwd_r  <= 1'b1;
      smp_cnt_r  <= '0;
    end else begin
      if ((state_r == ST_IDLE) && pick_vld_s) begin
        gnt_r     <= pick_s;
        cfg_fwd_r <= ~ch_inv[pick_s];
      end else begin
        gnt_r     <= gnt_r;
        cfg_fwd_r <= cfg_fwd_r;
      end
      if (push_s) last_gnt_r <= gnt_r;
      else        last_gnt_r <= last_gnt_r;
      if (state_r != ST_STREAM) smp_cnt_r <= '0;
      else if (data_hs_s)       smp_cnt_r <= last_s ? '0 : smp_cnt_r + LW'(1);
      else                      smp_cnt_r <= smp_cnt_r;
    end
  end

  // Output tag queue: pushed at frame end, popped as each FFT output frame ends.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      tag_cnt_r <= '0;
      for (int i = 0; i < 2**PW; i++) tag_mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= gnt_r;
        wr_ptr_r            <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      else       rd_ptr_r <= rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   tag_cnt_r <= tag_cnt_r + CW'(1);
        2'b01:   tag_cnt_r <= tag_cnt_r - CW'(1);
        default: tag_cnt_r <= tag_cnt_r;
      endcase
    end
  end

  // Sticky error: FFT framing events or a pop with nothing queued.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      err_r <= 1'b0;
    end else if (event_tlast_unexpected | event_tlast_missing | (pop_req_s & empty_s)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Output decode: data path is a pure pass-through of the granted channel in STREAM.
  always_comb begin
    ch_tready          = '0;
    s_axis_data_tdata  = '0;
    s_axis_data_tvalid = 1'b0;
    s_axis_data_tlast  = 1'b0;
    if (state_r == ST_STREAM) begin
      ch_tready[gnt_r]   = s_axis_data_tready;
      s_axis_data_tdata  = ch_tdata[gnt_r*DW +: DW];
      s_axis_data_tvalid = ch_tvalid[gnt_r];
      s_axis_data_tlast  = last_s;
    end else begin
      ch_tready          = '0;
      s_axis_data_tvalid = 1'b0;
      s_axis_data_tlast  = 1'b0;
    end
    s_axis_config_tvalid = (state_r == ST_CFG);
    s_axis_config_tdata  = {7'b0, cfg_fwd_r};
    frame_ch_vld         = ~empty_s;
    frame_ch_id          = empty_s ? '0 : tag_mem_r[rd_ptr_r];
    busy                 = (state_r != ST_IDLE);
    err_flag             = err_r;
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with FFT_LEN=16 and four channels.
// Each channel source emits {channel, running index}, so the bench knows
// exactly which sample must appear on every FFT input transfer.
module tb_fft_frame_scheduler;
  localparam int NUM_CH = 4, FFT_LEN = 16, DW = 48, MAX_INFLIGHT = 4, CHW = 2;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n;
  logic [NUM_CH*DW-1:0] ch_tdata;
  logic [NUM_CH-1:0]    ch_tvalid, ch_tready, ch_req, ch_inv;
  logic [7:0]           s_axis_config_tdata;
  logic                 s_axis_config_tvalid, s_axis_config_tready;
  logic [DW-1:0]        s_axis_data_tdata;
  logic                 s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tready;
  logic                 m_axis_data_tvalid, m_axis_data_tlast;
  logic                 event_tlast_unexpected, event_tlast_missing;
  logic [CHW-1:0]       frame_ch_id;
  logic                 frame_ch_vld, busy, err_flag;

  int checks = 0;
  int errors = 0;
  logic [39:0] src_cnt [NUM_CH];
  int exp_base [NUM_CH];

  always #5 sys_clk = ~sys_clk;

  fft_frame_scheduler #(
    .NUM_CH(NUM_CH), .FFT_LEN(FFT_LEN), .DW(DW), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .ch_tdata(ch_tdata), .ch_tvalid(ch_tvalid), .ch_tready(ch_tready),
    .ch_req(ch_req), .ch_inv(ch_inv),
    .s_axis_config_tdata(s_axis_config_tdata), .s_axis_config_tvalid(s_axis_config_tvalid),
    .s_axis_config_tready(s_axis_config_tready),
    .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
    .m_axis_data_tvalid(m_axis_data_tvalid), .m_axis_data_tlast(m_axis_data_tlast),
    .event_tlast_unexpected(event_tlast_unexpected), .event_tlast_missing(event_tlast_missing),
    .frame_ch_id(frame_ch_id), .frame_ch_vld(frame_ch_vld), .busy(busy), .err_flag(err_flag)
  );

  // Channel sources: sample word is {channel id, running sample index}.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) ch_tdata[k*DW +: DW] = {8'(k), src_cnt[k]};
  end

  // Source index advances only on an accepted sample.
  always @(posedge sys_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (!sys_rst_n) src_cnt[k] <= 40'd0;
      else if (ch_tvalid[k] && ch_tready[k]) src_cnt[k] <= src_cnt[k] + 40'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    ch_req = 4'b0; ch_inv = 4'b0; ch_tvalid = 4'b1111;
    s_axis_config_tready = 1'b1; s_axis_data_tready = 1'b1;
    m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
    event_tlast_unexpected = 1'b0; event_tlast_missing = 1'b0;
    for (int k = 0; k < NUM_CH; k++) exp_base[k] = 0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_ch_tready"}, ch_tready, 4'b0);
    check({pfx, "_cfg_tvalid"}, s_axis_config_tvalid, 1'b0);
    check({pfx, "_cfg_tdata"}, s_axis_config_tdata, 8'h01);
    check({pfx, "_data_tvalid"}, s_axis_data_tvalid, 1'b0);
    check({pfx, "_data_tlast"}, s_axis_data_tlast, 1'b0);
    check({pfx, "_frame_ch_id"}, frame_ch_id, 2'd0);
    check({pfx, "_frame_ch_vld"}, frame_ch_vld, 1'b0);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_err_flag"}, err_flag, 1'b0);
  endtask

  // Waits for the config beat, then follows the frame until stop_at samples moved.
  // Returns at the negedge of the last counted transfer.
  task automatic do_frame(input int ch, input logic [7:0] cfg, input bit stall,
                          input int stop_at, output int waited, output int cycles);
    int n;
    n = 0; waited = 0; cycles = 0;
    @(negedge sys_clk);
    while (!s_axis_config_tvalid && waited < 40) begin
      @(negedge sys_clk);
      waited++;
    end
    check("cfg_tvalid", s_axis_config_tvalid, 1'b1);
    check("cfg_tdata", s_axis_config_tdata, cfg);
    check("cfg_no_tready", ch_tready, 4'b0);
    while (n < stop_at && cycles < 400) begin
      @(posedge sys_clk); #1;
      if (stall) begin
        s_axis_data_tready = 1'($urandom_range(0, 1));
        ch_tvalid = 4'($urandom_range(0, 15));
      end
      @(negedge sys_clk);
      cycles++;
      check("tready_mask", ch_tready, s_axis_data_tready ? (64'd1 << ch) : 64'd0);
      check("tvalid_pass", s_axis_data_tvalid, ch_tvalid[ch]);
      if (s_axis_data_tvalid && s_axis_data_tready) begin
        check("sample", s_axis_data_tdata, {8'(ch), 40'(exp_base[ch] + n)});
        check("tlast", s_axis_data_tlast, n == FFT_LEN - 1);
        n++;
      end
    end
    check("frame_samples", n, stop_at);
    s_axis_data_tready = 1'b1;
    ch_tvalid = 4'b1111;
    if (n == FFT_LEN) exp_base[ch] += FFT_LEN;
  endtask

  initial begin
    int w, c;
    // Reset state
    apply_reset();
    check_reset_values("rst");
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("idle_no_req", busy, 1'b0);

    // Single channel, forward FFT
    ch_req = 4'b0001;
    do_frame(0, 8'h01, 1'b0, FFT_LEN, w, c);
    check("grant_latency", w, 0);
    check("best_case_cycles", c, FFT_LEN);
    ch_req = 4'b0000;
    @(negedge sys_clk);
    check("tag0_vld", frame_ch_vld, 1'b1);
    check("tag0_id", frame_ch_id, 2'd0);
    check("idle_after_frame", busy, 1'b0);
    m_axis_data_tvalid = 1'b1; m_axis_data_tlast = 1'b1;
    @(negedge sys_clk);
    m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
    check("tag0_popped", frame_ch_vld, 1'b0);
    check("no_err_valid_pop", err_flag, 1'b0);

    // Round-robin with ch2 inverse, then in-flight limit with no pops
    apply_reset();
    sys_rst_n = 1'b1;
    ch_inv = 4'b0100;
    ch_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      do_frame(i, (i == 2) ? 8'h00 : 8'h01, 1'b0, FFT_LEN, w, c);
      check("rr_gap", w, (i == 0) ? 0 : 1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      check("full_hold_busy", busy, 1'b0);
      check("full_hold_cfg", s_axis_config_tvalid, 1'b0);
    end
    check("full_head_id", frame_ch_id, 2'd0);
    check("full_head_vld", frame_ch_vld, 1'b1);
    m_axis_data_tvalid = 1'b1; m_axis_data_tlast = 1'b1;
    @(negedge sys_clk);
    m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
    check("pop_next_id", frame_ch_id, 2'd1);
    check("pop_cycle_idle", busy, 1'b0);
    do_frame(0, 8'h01, 1'b0, FFT_LEN, w, c);
    check("fifth_grant_latency", w, 0);
    ch_req = 4'b0000;

    // Backpressure on both sides of the data path
    apply_reset();
    sys_rst_n = 1'b1;
    ch_req = 4'b0010;
    do_frame(1, 8'h01, 1'b1, FFT_LEN, w, c);
    ch_req = 4'b0000;
    check("bp_grant_latency", w, 0);

    // Errors: missing tlast, then unexpected tlast, then pop on empty
    @(negedge sys_clk);
    check("err_clear", err_flag, 1'b0);
    event_tlast_missing = 1'b1;
    @(negedge sys_clk);
    event_tlast_missing = 1'b0;
    check("err_missing", err_flag, 1'b1);
    repeat (3) @(negedge sys_clk);
    check("err_sticky", err_flag, 1'b1);
    apply_reset();
    check("err_reset", err_flag, 1'b0);
    sys_rst_n = 1'b1;
    event_tlast_unexpected = 1'b1;
    @(negedge sys_clk);
    event_tlast_unexpected = 1'b0;
    check("err_unexpected", err_flag, 1'b1);
    apply_reset();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    m_axis_data_tvalid = 1'b1; m_axis_data_tlast = 1'b1;
    @(negedge sys_clk);
    m_axis_data_tvalid = 1'b0; m_axis_data_tlast = 1'b0;
    check("err_empty_pop", err_flag, 1'b1);
    check("empty_pop_vld", frame_ch_vld, 1'b0);

    // Reset in the middle of a frame while a tag is queued
    apply_reset();
    sys_rst_n = 1'b1;
    ch_req = 4'b0001;
    do_frame(0, 8'h01, 1'b0, FFT_LEN, w, c);
    do_frame(0, 8'h01, 1'b0, 7, w, c);
    check("second_frame_gap", w, 1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_reset_values("midrst");
    for (int k = 0; k < NUM_CH; k++) exp_base[k] = 0;
    ch_req = 4'b0011;
    sys_rst_n = 1'b1;
    do_frame(0, 8'h01, 1'b0, FFT_LEN, w, c);
    check("post_reset_first_grant", w, 0);
    ch_req = 4'b0000;
    @(negedge sys_clk);
    check("post_reset_tag", frame_ch_id, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
